// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: load/store ops,
// FSM states, access sizes and byte-enable lane constants.
package dmem_pkg;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LW   = 3'b011;
    localparam logic [2:0] LD_LBU  = 3'b100;
    localparam logic [2:0] LD_LHU  = 3'b101;

    localparam logic [2:0] ST_NONE = 3'b000;
    localparam logic [2:0] ST_SB   = 3'b001;
    localparam logic [2:0] ST_SH   = 3'b010;
    localparam logic [2:0] ST_SW   = 3'b011;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    function automatic logic ld_valid(input logic [2:0] op);
        return (op >= LD_LB) && (op <= LD_LHU);
    endfunction

    function automatic logic st_valid(input logic [2:0] op);
        return (op >= ST_SB) && (op <= ST_SW);
    endfunction

    function automatic size_t ld_size(input logic [2:0] op);
        size_t s;
        case (op)
            LD_LB, LD_LBU: s = SZ_B;
            LD_LH, LD_LHU: s = SZ_H;
            default:       s = SZ_W;
        endcase
        return s;
    endfunction

    function automatic size_t st_size(input logic [2:0] op);
        size_t s;
        case (op)
            ST_SB:   s = SZ_B;
            ST_SH:   s = SZ_H;
            default: s = SZ_W;
        endcase
        return s;
    endfunction

    function automatic logic ld_signed(input logic [2:0] op);
        return (op == LD_LB) || (op == LD_LH);
    endfunction

    function automatic logic misaligned(input size_t s, input logic [1:0] lane);
        return ((s == SZ_H) && lane[0]) || ((s == SZ_W) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables / replicated data,
// load lane extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_t       size,
    input  logic        sext,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] rdata
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        be     = BE_WORD;
        wlanes = wdata;
        rdata  = rword;
        b      = rword[8*lane +: 8];
        h      = lane[1] ? rword[31:16] : rword[15:0];
        // Half accesses use lane[1] only, so a misaligned half aligns down.
        case (size)
            SZ_B: begin
                be     = BE_BYTE << lane;
                wlanes = {4{wdata[7:0]}};
                rdata  = {{24{sext & b[7]}}, b};
            end
            SZ_H: begin
                be     = lane[1] ? BE_HI_HALF : BE_LO_HALF;
                wlanes = {2{wdata[15:0]}};
                rdata  = {{16{sext & h[15]}}, h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_busywait_responder.sv
// Fixed-latency data memory with pipeline stall output.
// Optional DMEM_MISALIGN_TRAP_EN suppresses and flags misaligned accesses.
module dmem_busywait_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  MEM_READ,
    input  logic [2:0]  MEM_WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY_WAIT
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        MISALIGNED
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            st_q;
    logic            both_q;
    logic            sext_q;
    size_t           size_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;

    logic            req_ld;
    logic            req_st;
    logic            req;
    logic            fire;
    logic            mis;
    logic            wr_en;
    logic [3:0]      be;
    logic [31:0]     wlanes;
    logic [31:0]     ld_data;
    logic [31:0]     rword;

    logic [31:0]     mem [DEPTH];

    assign req_ld = ld_valid(MEM_READ);
    assign req_st = st_valid(MEM_WRITE);
    assign req    = req_ld | req_st;
    assign fire   = (state == S_BUSY) && (cnt == '0);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = misaligned(size_q, addr_q[1:0]);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        BUSY_WAIT = 1'b0;
        case (state)
            S_IDLE: begin
                BUSY_WAIT = req;
                if (req) state_nx = S_BUSY;
            end
            S_BUSY: begin
                BUSY_WAIT = 1'b1;
                if (cnt == '0) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            st_q      <= 1'b0;
            both_q    <= 1'b0;
            sext_q    <= 1'b0;
            size_q    <= SZ_W;
            addr_q    <= '0;
            wdata_q   <= '0;
            READ_DATA <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req) begin
                // A store wins when both ops are presented together.
                st_q    <= req_st;
                both_q  <= req_st & req_ld;
                sext_q  <= ~req_st & ld_signed(MEM_READ);
                size_q  <= req_st ? st_size(MEM_WRITE) : ld_size(MEM_READ);
                addr_q  <= ADDRESS[AW+1:0];
                wdata_q <= WRITE_DATA;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == S_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (fire) begin
                if (mis || both_q) READ_DATA <= '0;
                else if (!st_q)    READ_DATA <= ld_data;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge CLK) begin
        if (RESET) MISALIGNED <= 1'b0;
        else       MISALIGNED <= fire & mis;
    end
`endif

    assign rword = mem[addr_q[AW+1:2]];

    dmem_lane_align u_align (
        .size   (size_q),
        .sext   (sext_q),
        .lane   (addr_q[1:0]),
        .wdata  (wdata_q),
        .rword  (rword),
        .be     (be),
        .wlanes (wlanes),
        .rdata  (ld_data)
    );

    // Reset in the completion cycle drops the pending store.
    assign wr_en = fire & st_q & ~mis & ~RESET;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_busywait_responder.sv
// Randomized self-checking bench against a byte-array reference model.
// Works with or without DMEM_MISALIGN_TRAP_EN.
module tb_dmem_busywait_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSY_WAIT;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        MISALIGNED;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0]  mm [DEPTH*4];
    logic [31:0] last_rd = '0;

    dmem_busywait_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MEM_READ   (MEM_READ),
        .MEM_WRITE  (MEM_WRITE),
        .ADDRESS    (ADDRESS),
        .WRITE_DATA (WRITE_DATA),
        .READ_DATA  (READ_DATA),
        .BUSY_WAIT  (BUSY_WAIT)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .MISALIGNED (MISALIGNED)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: returns expected READ_DATA and MISALIGNED.
    task automatic model(input logic [2:0] rd, input logic [2:0] wr,
                         input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] er, output logic em);
        bit st;
        bit ld;
        int n;
        int a;
        logic [31:0] v;
        st = (wr >= 1) && (wr <= 3);
        ld = (rd >= 1) && (rd <= 5);
        if (st)                     n = (wr == 1) ? 1 : (wr == 2) ? 2 : 4;
        else if (rd == 1 || rd == 4) n = 1;
        else if (rd == 2 || rd == 5) n = 2;
        else                         n = 4;
        a  = int'(ad & 32'(DEPTH*4 - 1));
        em = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        em = (a % n) != 0;
`endif
        a  = a - (a % n);
        er = last_rd;
        if (st) begin
            if (!em) for (int i = 0; i < n; i++) mm[a+i] = wd[8*i +: 8];
            if (em || ld) er = '0;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mm[a+i];
            if (em)          er = '0;
            else if (rd == 1) er = {{24{v[7]}}, v[7:0]};
            else if (rd == 2) er = {{16{v[15]}}, v[15:0]};
            else              er = v;
        end
        last_rd = er;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic req(input logic [2:0] rd, input logic [2:0] wr,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input string tag, output logic [31:0] got);
        logic [31:0] er;
        logic em;
        int busy;
        bit act;
        act = ((rd >= 1) && (rd <= 5)) || ((wr >= 1) && (wr <= 3));
        MEM_READ = rd;
        MEM_WRITE = wr;
        ADDRESS = ad;
        WRITE_DATA = wd;
        #1;
        if (!act) begin
            check({tag, "_idle_bw"}, {31'b0, BUSY_WAIT}, 32'd0);
            @(negedge CLK);
            MEM_READ = '0;
            MEM_WRITE = '0;
            check({tag, "_idle_rd"}, READ_DATA, last_rd);
            got = READ_DATA;
            return;
        end
        model(rd, wr, ad, wd, er, em);
        busy = 0;
        while (BUSY_WAIT === 1'b1 && busy < 20) begin
            busy++;
            @(posedge CLK);
            #1;
            MEM_READ = '0;
            MEM_WRITE = '0;
            ADDRESS = $urandom;
            WRITE_DATA = $urandom;
            @(negedge CLK);
        end
        MEM_READ = '0;
        MEM_WRITE = '0;
        check({tag, "_busy"}, 32'(busy), 32'(LATENCY + 1));
        check({tag, "_rd"}, READ_DATA, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        check({tag, "_mis"}, {31'b0, MISALIGNED}, {31'b0, em});
`endif
        got = READ_DATA;
        @(negedge CLK);
        check({tag, "_hold"}, READ_DATA, er);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] prior;
        logic [2:0]  rd;
        logic [2:0]  wr;

        RESET = 1'b1;
        MEM_READ = '0;
        MEM_WRITE = '0;
        ADDRESS = '0;
        WRITE_DATA = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_rd", READ_DATA, 32'd0);
        check("rst_bw", {31'b0, BUSY_WAIT}, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("rst_mis", {31'b0, MISALIGNED}, 32'd0);
`endif
        RESET = 1'b0;

        for (int w = 0; w < DEPTH; w++)
            req(3'd0, 3'd3, 32'(w*4), $urandom, "pre", got);

        req(3'd0, 3'd3, 32'h10, 32'hDEADBEEF, "sw10", got);
        req(3'd3, 3'd0, 32'h10, 32'h0, "lw10", got);
        check("lw10_k", got, 32'hDEADBEEF);
        req(3'd1, 3'd0, 32'h13, 32'h0, "lb13", got);
        check("lb13_k", got, 32'hFFFFFFDE);
        req(3'd4, 3'd0, 32'h13, 32'h0, "lbu13", got);
        check("lbu13_k", got, 32'h000000DE);
        req(3'd2, 3'd0, 32'h10, 32'h0, "lh10", got);
        check("lh10_k", got, 32'hFFFFBEEF);
        req(3'd5, 3'd0, 32'h12, 32'h0, "lhu12", got);
        check("lhu12_k", got, 32'h0000DEAD);
        req(3'd0, 3'd1, 32'h11, 32'h00000055, "sb11", got);
        req(3'd3, 3'd0, 32'h10, 32'h0, "lw10b", got);
        check("lw10b_k", got, 32'hDEAD55EF);

        prior = {mm[32'h23], mm[32'h22], mm[32'h21], mm[32'h20]};
        MEM_WRITE = 3'd3;
        ADDRESS = 32'h20;
        WRITE_DATA = 32'h12345678;
        #1;
        check("mrst_bw0", {31'b0, BUSY_WAIT}, 32'd1);
        @(posedge CLK);
        #1;
        MEM_WRITE = '0;
        @(negedge CLK);
        check("mrst_bw1", {31'b0, BUSY_WAIT}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("mrst_bw", {31'b0, BUSY_WAIT}, 32'd0);
        check("mrst_rd", READ_DATA, 32'd0);
        RESET = 1'b0;
        last_rd = '0;
        req(3'd3, 3'd0, 32'h20, 32'h0, "lw20", got);
        check("lw20_k", got, prior);

        req(3'd3, 3'd3, 32'h30, 32'hA5A5A5A5, "both30", got);
        check("both30_k", got, 32'd0);
        req(3'd3, 3'd0, 32'h30, 32'h0, "lw30", got);
        check("lw30_k", got, 32'hA5A5A5A5);

        req(3'd3, 3'd0, 32'h22, 32'h0, "lw22", got);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw22_k", got, 32'd0);
`else
        check("lw22_k", got, prior);
`endif

        for (int i = 0; i < 400; i++) begin
            rd = 3'($urandom_range(0, 7));
            wr = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            req(rd, wr, $urandom, $urandom, "rnd", got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
